// File: rtl/fnn_pkg.sv
// Shared types and defaults for the output layer.
// Holds the controller state encoding, default score geometry and the index-width helper.
package fnn_pkg;

   localparam int FNN_SCORE_W     = 47;
   localparam int FNN_NUM_CLASSES = 10;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      HOLD
   } ctrl_state_t;

   // Bits needed to address n entries, never less than one.
   function automatic int idx_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running argmax over a stream of signed scores; the first score of a run loads unconditionally.
// Optional runner-up tracking and margin output under MARGIN_OUT_EN.
module argmax_tracker
   import fnn_pkg::*;
#(
   parameter int DATA_W = FNN_SCORE_W,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid,
   input  logic              first,
   input  logic [DATA_W-1:0] score,
   input  logic [IDX_W-1:0]  idx,
   output logic [DATA_W-1:0] max_score,
   output logic [IDX_W-1:0]  class_idx
`ifdef MARGIN_OUT_EN
   ,
   output logic [DATA_W:0]   margin
`endif
);

   logic beats_max;

   // Strictly greater only, so an equal later score never displaces a lower index.
   assign beats_max = $signed(score) > $signed(max_score);

   always_ff @(posedge clk) begin
      if (reset) begin
         max_score <= '0;
         class_idx <= '0;
      end else if (valid && (first || beats_max)) begin
         max_score <= score;
         class_idx <= idx;
      end
   end

`ifdef MARGIN_OUT_EN
   logic [DATA_W-1:0] runner_up;
   logic              runner_vld;
   logic              beats_runner;

   assign beats_runner = !runner_vld || ($signed(score) > $signed(runner_up));

   always_ff @(posedge clk) begin
      if (reset) begin
         runner_up  <= '0;
         runner_vld <= 1'b0;
      end else if (valid) begin
         if (first) begin
            runner_vld <= 1'b0;
         end else if (beats_max) begin
            runner_up  <= max_score;
            runner_vld <= 1'b1;
         end else if (beats_runner) begin
            runner_up  <= score;
            runner_vld <= 1'b1;
         end
      end
   end

   // Sign-extended subtract; max is never below runner-up, so the result is non-negative.
   assign margin = runner_vld ?
                   ({max_score[DATA_W-1], max_score} - {runner_up[DATA_W-1], runner_up}) :
                   '0;
`endif

endmodule

// File: rtl/output_argmax_controller.sv
// Streams NUM_CLASSES scores from the score buffer into an argmax and offers the winner on valid/ready.
// Optional margin output (max minus runner-up) is enabled by defining MARGIN_OUT_EN.
module output_argmax_controller
   import fnn_pkg::*;
#(
   parameter int DATA_W      = FNN_SCORE_W,
   parameter int NUM_CLASSES = FNN_NUM_CLASSES,
   parameter int IDX_W       = idx_width(NUM_CLASSES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              rd_en,
   output logic [IDX_W-1:0]  rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [IDX_W-1:0]  class_idx,
   output logic [DATA_W-1:0] max_score
`ifdef MARGIN_OUT_EN
   ,
   output logic [DATA_W:0]   margin
`endif
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   ctrl_state_t      state;
   ctrl_state_t      state_nxt;
   logic             rd_vld;
   logic [IDX_W-1:0] rd_idx;
   logic             last_vld;

   // rd_vld/rd_idx follow the read strobe by one cycle to line up with rd_data;
   // last_vld marks that the final score has been folded into the tracker.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rd_addr  <= '0;
         rd_vld   <= 1'b0;
         rd_idx   <= '0;
         last_vld <= 1'b0;
      end else begin
         state    <= state_nxt;
         rd_vld   <= rd_en;
         rd_idx   <= rd_addr;
         last_vld <= rd_vld && (rd_idx == LAST_IDX);
         if (state == IDLE && start) begin
            rd_addr <= '0;
         end else if (state == FETCH && rd_addr != LAST_IDX) begin
            rd_addr <= rd_addr + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      busy         = 1'b1;
      rd_en        = 1'b0;
      result_valid = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            rd_en = 1'b1;
            if (rd_addr == LAST_IDX) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (last_vld) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            result_valid = 1'b1;
            if (result_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   argmax_tracker #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_tracker (
      .clk       (clk),
      .reset     (reset),
      .valid     (rd_vld),
      .first     (rd_idx == '0),
      .score     (rd_data),
      .idx       (rd_idx),
      .max_score (max_score),
      .class_idx (class_idx)
`ifdef MARGIN_OUT_EN
      ,
      .margin    (margin)
`endif
   );

endmodule
